// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory requesters, the arbiter and the memory.
// slave = arbiter view; master = requesters plus memory model.
interface dmem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          core_req;
    logic          core_we;
    logic [AW-1:0] core_addr;
    logic [2:0]    core_funct3;
    logic [DW-1:0] core_wdata;
    logic          core_gnt;
    logic          core_stall;
    logic          core_rvalid;
    logic [DW-1:0] core_rdata;

    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [2:0]    dbg_funct3;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_lock;
    logic          dbg_gnt;
    logic          dbg_rvalid;
    logic [DW-1:0] dbg_rdata;

    logic          mem_memwrite;
    logic [AW-1:0] mem_addr;
    logic [2:0]    mem_load_type;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  core_req, core_we, core_addr, core_funct3, core_wdata,
        output core_gnt, core_stall, core_rvalid, core_rdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_funct3, dbg_wdata, dbg_lock,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_memwrite, mem_addr, mem_load_type, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output core_req, core_we, core_addr, core_funct3, core_wdata,
        input  core_gnt, core_stall, core_rvalid, core_rdata,
        output dbg_req, dbg_we, dbg_addr, dbg_funct3, dbg_wdata, dbg_lock,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_memwrite, mem_addr, mem_load_type, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-way data-memory arbiter (core vs debug) with combinational grant, debug bus lock
// and one-cycle registered read return per requester.
module dmem_arbiter #(
    parameter int unsigned ARB_MODE = 0,
    parameter int unsigned MAX_WAIT = 8,
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32
) (
    input logic           i_clk,
    input logic           i_resetn,
    dmem_arbiter_if.slave bus
);
    localparam logic ST_ARB    = 1'b0;
    localparam logic ST_LOCKED = 1'b1;
    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    logic          r_state;
    logic          r_last_gnt;
    logic [7:0]    r_wait_cnt;
    logic          r_core_rvalid;
    logic [DW-1:0] r_core_rdata;
    logic          r_dbg_rvalid;
    logic [DW-1:0] r_dbg_rdata;

    logic          w_core_gnt;
    logic          w_dbg_gnt;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [2:0]    w_funct3;
    logic [DW-1:0] w_wdata;
    logic [7:0]    w_wait_d;
    logic          w_state_d;

    // Grants are forced low during reset so no write can slip through.
    always_comb begin
        w_core_gnt = 1'b0;
        w_dbg_gnt  = 1'b0;
        if (i_resetn) begin
            if (r_state == ST_LOCKED) begin
                w_dbg_gnt = bus.dbg_req;
            end else if (ARB_MODE == 0) begin
                if (bus.core_req && bus.dbg_req) begin
                    w_core_gnt = r_last_gnt;
                    w_dbg_gnt  = ~r_last_gnt;
                end else begin
                    w_core_gnt = bus.core_req;
                    w_dbg_gnt  = bus.dbg_req;
                end
            end else begin
                w_dbg_gnt  = bus.dbg_req && (!bus.core_req || r_wait_cnt == LP_MAX_WAIT);
                w_core_gnt = bus.core_req && !w_dbg_gnt;
            end
        end
    end

    always_comb begin
        w_we     = 1'b0;
        w_addr   = '0;
        w_funct3 = '0;
        w_wdata  = '0;
        if (w_core_gnt) begin
            w_we     = bus.core_we;
            w_addr   = bus.core_addr;
            w_funct3 = bus.core_funct3;
            w_wdata  = bus.core_wdata;
        end else if (w_dbg_gnt) begin
            w_we     = bus.dbg_we;
            w_addr   = bus.dbg_addr;
            w_funct3 = bus.dbg_funct3;
            w_wdata  = bus.dbg_wdata;
        end
    end

    always_comb begin
        w_wait_d = 8'd0;
        if (ARB_MODE == 1 && bus.dbg_req && !w_dbg_gnt) begin
            w_wait_d = (r_wait_cnt == LP_MAX_WAIT) ? r_wait_cnt : r_wait_cnt + 8'd1;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_ARB:    if (w_dbg_gnt && bus.dbg_lock) w_state_d = ST_LOCKED;
            ST_LOCKED: if (!bus.dbg_lock) w_state_d = ST_ARB;
            default:   w_state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_state       <= ST_ARB;
            r_last_gnt    <= 1'b1;
            r_wait_cnt    <= 8'd0;
            r_core_rvalid <= 1'b0;
            r_core_rdata  <= '0;
            r_dbg_rvalid  <= 1'b0;
            r_dbg_rdata   <= '0;
        end else begin
            r_state    <= w_state_d;
            r_wait_cnt <= w_wait_d;
            if (w_core_gnt) begin
                r_last_gnt <= 1'b0;
            end else if (w_dbg_gnt) begin
                r_last_gnt <= 1'b1;
            end
            r_core_rvalid <= w_core_gnt && !bus.core_we;
            if (w_core_gnt && !bus.core_we) begin
                r_core_rdata <= bus.mem_rdata;
            end
            r_dbg_rvalid <= w_dbg_gnt && !bus.dbg_we;
            if (w_dbg_gnt && !bus.dbg_we) begin
                r_dbg_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.core_gnt      = w_core_gnt;
    assign bus.core_stall    = bus.core_req && !w_core_gnt;
    assign bus.core_rvalid   = r_core_rvalid;
    assign bus.core_rdata    = r_core_rdata;
    assign bus.dbg_gnt       = w_dbg_gnt;
    assign bus.dbg_rvalid    = r_dbg_rvalid;
    assign bus.dbg_rdata     = r_dbg_rdata;
    assign bus.mem_memwrite  = w_we;
    assign bus.mem_addr      = w_addr;
    assign bus.mem_load_type = w_funct3;
    assign bus.mem_wdata     = w_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and a core-priority instance
// (MAX_WAIT=4) share clock, reset and stimulus.
module tb_dmem_arbiter;
    logic clk;
    logic resetn;
    int   n_chk;
    int   n_fail;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus0 ();
    dmem_arbiter_if #(.AW(32), .DW(32)) bus1 ();

    dmem_arbiter #(.ARB_MODE(0), .MAX_WAIT(8), .AW(32), .DW(32)) u_rr (
        .i_clk    (clk),
        .i_resetn (resetn),
        .bus      (bus0)
    );

    dmem_arbiter #(.ARB_MODE(1), .MAX_WAIT(4), .AW(32), .DW(32)) u_pri (
        .i_clk    (clk),
        .i_resetn (resetn),
        .bus      (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rstn;
        logic        creq;
        logic        cwe;
        logic [31:0] caddr;
        logic        dreq;
        logic        dwe;
        logic        dlock;
        logic [31:0] daddr;
        logic [31:0] mrd;
        logic        cgnt;
        logic        dgnt;
        logic        stall;
        logic        mwe;
        logic [31:0] maddr;
        logic        crv;
        logic [31:0] crd;
        logic        drv;
        logic [31:0] drd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive both instances at the falling edge, then let combinational outputs settle.
    task automatic drive(input logic rstn, input logic creq, input logic cwe,
                         input logic [31:0] caddr, input logic dreq, input logic dwe,
                         input logic dlock, input logic [31:0] daddr, input logic [31:0] mrd);
        @(negedge clk);
        resetn = rstn;
        bus0.core_req = creq;  bus1.core_req = creq;
        bus0.core_we = cwe;    bus1.core_we = cwe;
        bus0.core_addr = caddr; bus1.core_addr = caddr;
        bus0.core_funct3 = 3'b010; bus1.core_funct3 = 3'b010;
        bus0.core_wdata = 32'hC000_0000 ^ caddr; bus1.core_wdata = 32'hC000_0000 ^ caddr;
        bus0.dbg_req = dreq;   bus1.dbg_req = dreq;
        bus0.dbg_we = dwe;     bus1.dbg_we = dwe;
        bus0.dbg_lock = dlock; bus1.dbg_lock = dlock;
        bus0.dbg_addr = daddr; bus1.dbg_addr = daddr;
        bus0.dbg_funct3 = 3'b001; bus1.dbg_funct3 = 3'b001;
        bus0.dbg_wdata = 32'hD000_0000 ^ daddr; bus1.dbg_wdata = 32'hD000_0000 ^ daddr;
        bus0.mem_rdata = mrd;  bus1.mem_rdata = mrd;
        #1;
    endtask

    initial begin
        logic [31:0] exp_wd;
        logic [2:0]  exp_f3;
        n_chk  = 0;
        n_fail = 0;

        // rstn creq cwe caddr | dreq dwe dlock daddr | mrd || cgnt dgnt stall mwe maddr crv crd drv drd
        vecs[0]  = '{0, 1, 1, 32'h20,  0, 0, 0, 32'h0,   32'h0,
                     0, 0, 1, 0, 32'h0,   0, 32'h0,        0, 32'h0};
        vecs[1]  = vecs[0];
        vecs[2]  = vecs[0];
        vecs[3]  = '{1, 1, 1, 32'h20,  0, 0, 0, 32'h0,   32'h0,
                     1, 0, 0, 1, 32'h20,  0, 32'h0,        0, 32'h0};
        vecs[4]  = '{1, 1, 0, 32'h10,  0, 0, 0, 32'h0,   32'hDEADBEEF,
                     1, 0, 0, 0, 32'h10,  0, 32'h0,        0, 32'h0};
        vecs[5]  = '{1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h12345678,
                     0, 0, 0, 0, 32'h0,   1, 32'hDEADBEEF, 0, 32'h0};
        vecs[6]  = '{1, 0, 0, 32'h0,   0, 0, 0, 32'h0,   32'h0,
                     0, 0, 0, 0, 32'h0,   0, 32'hDEADBEEF, 0, 32'h0};
        vecs[7]  = '{1, 1, 0, 32'h100, 1, 0, 0, 32'h200, 32'hA7,
                     0, 1, 1, 0, 32'h200, 0, 32'hDEADBEEF, 0, 32'h0};
        vecs[8]  = '{1, 1, 0, 32'h100, 1, 0, 0, 32'h200, 32'hA8,
                     1, 0, 0, 0, 32'h100, 0, 32'hDEADBEEF, 1, 32'hA7};
        vecs[9]  = '{1, 1, 0, 32'h100, 1, 0, 0, 32'h200, 32'hA9,
                     0, 1, 1, 0, 32'h200, 1, 32'hA8,       0, 32'hA7};
        vecs[10] = '{1, 1, 0, 32'h100, 1, 0, 0, 32'h200, 32'hAA,
                     1, 0, 0, 0, 32'h100, 0, 32'hA8,       1, 32'hA9};
        vecs[11] = '{1, 0, 0, 32'h0,   1, 1, 0, 32'h204, 32'hBB,
                     0, 1, 0, 1, 32'h204, 1, 32'hAA,       0, 32'hA9};
        vecs[12] = '{1, 0, 0, 32'h0,   1, 1, 0, 32'h204, 32'hCC,
                     0, 1, 0, 1, 32'h204, 0, 32'hAA,       0, 32'hA9};

        // Prelude edge so registered outputs are defined before the first row.
        drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rstn, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].dreq,
                  vecs[i].dwe, vecs[i].dlock, vecs[i].daddr, vecs[i].mrd);
            exp_wd = vecs[i].cgnt ? (32'hC000_0000 ^ vecs[i].caddr) :
                     vecs[i].dgnt ? (32'hD000_0000 ^ vecs[i].daddr) : 32'h0;
            exp_f3 = vecs[i].cgnt ? 3'b010 : vecs[i].dgnt ? 3'b001 : 3'b000;
            chk($sformatf("v%0d core_gnt", i),    32'(bus0.core_gnt),      32'(vecs[i].cgnt));
            chk($sformatf("v%0d dbg_gnt", i),     32'(bus0.dbg_gnt),       32'(vecs[i].dgnt));
            chk($sformatf("v%0d core_stall", i),  32'(bus0.core_stall),    32'(vecs[i].stall));
            chk($sformatf("v%0d mem_memwrite", i), 32'(bus0.mem_memwrite), 32'(vecs[i].mwe));
            chk($sformatf("v%0d mem_addr", i),    bus0.mem_addr,           vecs[i].maddr);
            chk($sformatf("v%0d mem_wdata", i),   bus0.mem_wdata,          exp_wd);
            chk($sformatf("v%0d mem_load_type", i), 32'(bus0.mem_load_type), 32'(exp_f3));
            chk($sformatf("v%0d core_rvalid", i), 32'(bus0.core_rvalid),   32'(vecs[i].crv));
            chk($sformatf("v%0d core_rdata", i),  bus0.core_rdata,         vecs[i].crd);
            chk($sformatf("v%0d dbg_rvalid", i),  32'(bus0.dbg_rvalid),    32'(vecs[i].drv));
            chk($sformatf("v%0d dbg_rdata", i),   bus0.dbg_rdata,          vecs[i].drd);
        end

        // Both requesting continuously: round-robin alternates, core-priority gives dbg
        // every fifth cycle once its wait count reaches MAX_WAIT=4.
        drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 0, 32'h100, 1, 0, 0, 32'h200, 32'h0);
            chk($sformatf("rr%0d core_gnt", i),  32'(bus0.core_gnt), 32'((i % 2) == 0));
            chk($sformatf("rr%0d dbg_gnt", i),   32'(bus0.dbg_gnt),  32'((i % 2) == 1));
            chk($sformatf("pri%0d core_gnt", i), 32'(bus1.core_gnt), 32'((i % 5) != 4));
            chk($sformatf("pri%0d dbg_gnt", i),  32'(bus1.dbg_gnt),  32'((i % 5) == 4));
            chk($sformatf("pri%0d wait_le_max", i), 32'(u_pri.r_wait_cnt <= 8'd4), 32'd1);
        end

        // Locked debug write burst holds the core off until the edge after lock drops.
        drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 1, 0, 32'h40, 0, 0, 0, 32'h0, 32'h0);
        chk("lk pre core_gnt", 32'(bus0.core_gnt), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 32'h40, 1, 1, 1, 32'(4 * i), 32'h0);
            chk($sformatf("lk%0d dbg_gnt", i),  32'(bus0.dbg_gnt),      32'd1);
            chk($sformatf("lk%0d core_gnt", i), 32'(bus0.core_gnt),     32'd0);
            chk($sformatf("lk%0d memwrite", i), 32'(bus0.mem_memwrite), 32'd1);
            chk($sformatf("lk%0d mem_addr", i), bus0.mem_addr,          32'(4 * i));
        end
        drive(1, 1, 0, 32'h40, 0, 0, 1, 32'h0, 32'h0);
        chk("lk idle core_gnt", 32'(bus0.core_gnt), 32'd0);
        chk("lk idle memwrite", 32'(bus0.mem_memwrite), 32'd0);
        chk("lk idle stall", 32'(bus0.core_stall), 32'd1);
        drive(1, 1, 0, 32'h40, 0, 0, 0, 32'h0, 32'h0);
        chk("lk drop core_gnt", 32'(bus0.core_gnt), 32'd0);
        drive(1, 1, 0, 32'h40, 0, 0, 0, 32'h0, 32'h0);
        chk("lk after core_gnt", 32'(bus0.core_gnt), 32'd1);
        chk("lk after mem_addr", bus0.mem_addr, 32'h40);

        // Reset in the middle of a locked burst must clear the lock and block writes.
        drive(0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
        drive(1, 0, 0, 32'h0, 1, 1, 1, 32'h10, 32'h0);
        chk("mr lock dbg_gnt", 32'(bus0.dbg_gnt), 32'd1);
        drive(1, 1, 1, 32'h30, 1, 1, 1, 32'h14, 32'h0);
        chk("mr locked core_gnt", 32'(bus0.core_gnt), 32'd0);
        drive(0, 1, 1, 32'h30, 1, 1, 1, 32'h18, 32'h0);
        chk("mr rst dbg_gnt", 32'(bus0.dbg_gnt), 32'd0);
        chk("mr rst core_gnt", 32'(bus0.core_gnt), 32'd0);
        chk("mr rst memwrite", 32'(bus0.mem_memwrite), 32'd0);
        chk("mr rst memwrite pri", 32'(bus1.mem_memwrite), 32'd0);
        drive(1, 1, 1, 32'h30, 0, 0, 1, 32'h0, 32'h0);
        chk("mr rel core_gnt", 32'(bus0.core_gnt), 32'd1);
        chk("mr rel memwrite", 32'(bus0.mem_memwrite), 32'd1);
        chk("mr rel mem_addr", bus0.mem_addr, 32'h30);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: the core load/store path ("core") and a debug/program-loader port ("dbg").
- Arbitration is combinational, within the request cycle. The memory is driven from the winner.
- Read data is registered and returned one cycle after grant.
- The core uses core_stall to hold its PC while it loses arbitration.

Parameters:
- ARB_MODE, 0, arbitration policy: 0 = round-robin; 1 = core-priority with dbg starvation guard.
- MAX_WAIT, 8, ARB_MODE=1 only: consecutive cycles dbg may be denied before it is forced a grant (1..255).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- core_req  in  1  core access request (level; held until granted)
- core_we  in  1  1 = store, 0 = load
- core_addr  in  AW  byte address
- core_funct3  in  3  load/store type, passed to memory
- core_wdata  in  DW  store data
- core_gnt  out  1  combinational grant this cycle
- core_stall  out  1  core_req & ~core_gnt
- core_rvalid  out  1  registered; load data valid
- core_rdata  out  DW  registered load data
- dbg_req, dbg_we, dbg_addr, dbg_funct3, dbg_wdata  in  1/1/AW/3/DW  same meaning for dbg
- dbg_lock  in  1  hold bus for dbg while asserted (burst)
- dbg_gnt  out  1  combinational grant
- dbg_rvalid  out  1  registered
- dbg_rdata  out  DW  registered
- mem_memwrite  out  1  write strobe to data memory
- mem_addr  out  AW  to memory
- mem_load_type  out  3  funct3 to memory
- mem_wdata  out  DW  to memory
- mem_rdata  in  DW  combinational read data from memory

Behaviour:
- State register: ARB / LOCKED.
  - last_gnt: 0 = core, 1 = dbg.
  - wait_cnt: 8 bits.
- Reset (resetn=0 at edge): state=ARB, last_gnt=1 (core wins first tie), wait_cnt=0, core_rvalid=dbg_rvalid=0, core_rdata=dbg_rdata=0.
- While resetn=0, core_gnt=dbg_gnt=0 and mem_memwrite=0 combinationally. This prevents writes during reset, including reset asserted mid-transfer.
- Grant, state ARB, ARB_MODE=0:
  - Single requester wins.
  - Both requesting: the one not equal to last_gnt wins.
- Grant, state ARB, ARB_MODE=1:
  - Core wins unless wait_cnt==MAX_WAIT, in which case dbg wins.
  - dbg wins if core idle.
- Grant, state LOCKED: only dbg may be granted. core_gnt=0 regardless of core_req.
- At most one gnt high per cycle. gnt only asserted when the matching req=1.
- Mem mux:
  - Winner's addr/funct3/wdata drive memory.
  - mem_memwrite = winner_we.
  - No grant: mem_memwrite=0, mem_addr=0, mem_load_type=0, mem_wdata=0.
- Read latency 1:
  - On the edge ending a granted load, x_rdata <= mem_rdata and x_rvalid <= 1.
  - Otherwise x_rvalid <= 0 and x_rdata holds.
  - Writes never raise rvalid.
- last_gnt updates to the winner on any granted cycle. It holds when there is no grant.
- wait_cnt (ARB_MODE=1):
  - Increments, saturating at MAX_WAIT, when dbg_req & ~dbg_gnt.
  - Clears to 0 when dbg_gnt or ~dbg_req.
  - Unused (held 0) in mode 0.
- FSM:
  - ARB -> LOCKED when dbg_gnt & dbg_lock.
  - LOCKED -> ARB on first edge with dbg_lock=0; core is eligible the following cycle.
  - LOCKED with dbg_req=0 and dbg_lock=1: bus idle, stays LOCKED.
- Simultaneous events:
  - Grant and lock assertion in the same cycle: the access proceeds and the lock takes effect from the next cycle.
  - Request dropped without grant: legal, no side effect.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with core_req=1, core_we=1 -> core_gnt=0, mem_memwrite=0, all rvalid/rdata=0. Release -> core_gnt=1 the same cycle.
- Core load alone: core_req=1, we=0, addr=0x10, mem_rdata=0xDEADBEEF -> core_gnt=1 in cycle N, core_rvalid=1 and core_rdata=0xDEADBEEF in N+1, core_rvalid=0 in N+2.
- Round-robin (ARB_MODE=0): both request continuously for 6 cycles -> grants alternate core,dbg,core,dbg,core,dbg. core_stall=1 on dbg cycles.
- Starvation guard (ARB_MODE=1, MAX_WAIT=4): both request continuously -> core granted 4 cycles, dbg granted cycle 5, pattern repeats. wait_cnt never exceeds 4.
- Lock burst: dbg writes 0x0,0x4,0x8 with dbg_lock=1 while core_req=1 -> dbg_gnt 3 cycles, mem_memwrite=1 each, core_gnt=0. Drop lock -> core granted the next cycle.
- Mid-burst reset: resetn=0 during LOCKED -> next cycle state ARB, core_gnt=1 after release, no write strobe while reset is low.
